// File: rtl/dpram_pkg.sv
// Shared types and constants for the byte-enabled dual-port RAM.
// Optional same-address write bypass is selected with DPRAM_WR_BYPASS_EN.
package dpram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } dpram_state_e;

  localparam int unsigned RD_LAT_1 = 1;
  localparam int unsigned RD_LAT_2 = 2;

endpackage

// File: rtl/dpram_core.sv
// Storage array: byte-enabled synchronous write, registered read that holds between reads.
// Bypass option DPRAM_WR_BYPASS_EN lives in the top level, not here.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clock_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W/8-1:0]   wr_be_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the array has no reset; it maps onto RAM macros, and the top-level clear sweep initialises it.
  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
    // Read-first: the read sees the word as it was before this edge's write.
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/param_dual_port_ram.sv
// Dual-port RAM top: clear-on-reset FSM, read pipeline (latency 1 or 2), optional
// same-address write bypass enabled by the macro DPRAM_WR_BYPASS_EN.
module param_dual_port_ram
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = RD_LAT_1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     write_address,
  input  logic [DATA_W/8-1:0]   write_be,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  read_en,
  input  logic [ADDR_W-1:0]     read_address,
  output logic [DATA_W-1:0]     data_out,
  output logic                  read_valid,
  output logic                  init_done
);

  localparam int unsigned       NB        = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dpram_state_e      state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [NB-1:0]     core_wbe;
  logic [DATA_W-1:0] core_wdata;
  logic              wr_accept;
  logic              rd_accept;
  logic [DATA_W-1:0] core_rdata;
  logic [DATA_W-1:0] stage1_word;
  logic              rd_valid1_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    core_we    = 1'b0;
    core_waddr = write_address;
    core_wbe   = write_be;
    core_wdata = data_in;
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    unique case (state_q)
      INIT: begin
        core_we    = ~reset;
        core_waddr = clr_cnt_q;
        core_wbe   = '1;
        core_wdata = '0;
        // Counter stops at the last address rather than wrapping.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      READY: begin
        wr_accept = write_en & ~reset;
        rd_accept = read_en & ~reset;
        core_we   = wr_accept;
      end
      default: state_d = INIT;
    endcase
  end

  assign init_done = (state_q == READY);

  dpram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clock_i   (clock),
    .wr_en_i   (core_we),
    .wr_addr_i (core_waddr),
    .wr_be_i   (core_wbe),
    .wr_data_i (core_wdata),
    .rd_en_i   (rd_accept),
    .rd_addr_i (read_address),
    .rd_data_o (core_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) rd_valid1_q <= 1'b0;
    else       rd_valid1_q <= rd_accept;
  end

`ifdef DPRAM_WR_BYPASS_EN
  logic [NB-1:0]     byp_be_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] byp_mask;

  // Captured alongside each accepted read so the merge holds with the read data.
  always_ff @(posedge clock) begin
    if (rd_accept) begin
      byp_be_q   <= (wr_accept && (write_address == read_address)) ? write_be : '0;
      byp_data_q <= data_in;
    end
  end

  always_comb begin
    byp_mask = '0;
    for (int b = 0; b < NB; b++) byp_mask[8*b +: 8] = {8{byp_be_q[b]}};
    stage1_word = (core_rdata & ~byp_mask) | (byp_data_q & byp_mask);
  end
`else
  assign stage1_word = core_rdata;
`endif

  if (RD_LATENCY == RD_LAT_2) begin : g_lat2
    logic              valid2_q;
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        valid2_q <= 1'b0;
        dout_q   <= '0;
      end else begin
        valid2_q <= rd_valid1_q;
        if (rd_valid1_q) dout_q <= stage1_word;
      end
    end

    assign data_out   = dout_q;
    assign read_valid = valid2_q;
  end else begin : g_lat1
    // The core read register has no reset; mask it to zero until the first read after reset.
    logic out_zero_q;

    always_ff @(posedge clock) begin
      if (reset)          out_zero_q <= 1'b1;
      else if (rd_accept) out_zero_q <= 1'b0;
    end

    assign data_out   = out_zero_q ? '0 : stage1_word;
    assign read_valid = rd_valid1_q;
  end

endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LATENCY, default 1: read latency in cycles; legal values 1 and 2.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port write_en, input, 1 bit: write request.
REQ-007 SHALL have port write_address, input, ADDR_W bits: write word address.
REQ-008 SHALL have port write_be, input, DATA_W/8 bits: byte enables; bit i enables data_in[8i+7:8i].
REQ-009 SHALL have port data_in, input, DATA_W bits: write data.
REQ-010 SHALL have port read_en, input, 1 bit: read request.
REQ-011 SHALL have port read_address, input, ADDR_W bits: read word address.
REQ-012 SHALL have port data_out, output, DATA_W bits: read data.
REQ-013 SHALL have port read_valid, output, 1 bit: data_out carries the result of a read this cycle.
REQ-014 SHALL have port init_done, output, 1 bit: memory clear complete; accesses accepted.

Function
REQ-015 SHALL implement an FSM with states INIT and READY; reset forces INIT with clear counter 0.
REQ-016 In INIT, the block SHALL write all-zero to address counter value each cycle, incrementing by 1.
REQ-017 INIT SHALL transition to READY on the cycle the counter equals DEPTH-1, so clearing takes exactly DEPTH cycles.
REQ-018 init_done SHALL be 0 in INIT and 1 in READY.
REQ-019 In INIT, write_en and read_en SHALL be ignored: no user write, and read_valid stays 0.
REQ-020 In READY, write_en=1 SHALL update only the bytes of mem[write_address] whose write_be bit is 1, at that edge.
REQ-021 write_en=1 with write_be all zero SHALL leave memory unchanged.
REQ-022 In READY, read_en=1 sampled at edge N SHALL drive data_out and read_valid=1 after edge N+RD_LATENCY-1, i.e. visible in cycle N+RD_LATENCY.
REQ-023 read_valid SHALL be a single-cycle pulse per accepted read; back-to-back reads SHALL give back-to-back valids, one read per cycle.
REQ-024 data_out SHALL hold its last value when no read completes.
REQ-025 Reads and writes to different addresses in the same cycle SHALL be independent.
REQ-026 Same-address read and write in the same cycle SHALL return the old stored word, unless REQ-031 applies.
REQ-027 The clear counter SHALL not wrap; READY SHALL persist until the next reset.

Reset
REQ-028 On reset=1 at an edge, data_out SHALL become 0, read_valid 0, init_done 0, and the FSM INIT.
REQ-029 Reset asserted mid-INIT or mid-read SHALL restart the clear from address 0 and discard in-flight reads, with no read_valid emitted.
REQ-030 Memory contents SHALL be defined only after init_done=1.

Configuration
REQ-031 With macro DPRAM_WR_BYPASS_EN defined, a same-address same-cycle read SHALL return the merged word: new bytes where write_be=1, old bytes elsewhere.
REQ-032 Without DPRAM_WR_BYPASS_EN, read-first behaviour as in REQ-026 SHALL apply, and no bypass logic SHALL be present.

Structure
REQ-033 Package dpram_pkg SHALL hold the FSM state enum (INIT, READY) and the RD_LATENCY legal-value constants.
REQ-034 The storage array SHALL be a sub-module dpram_core: byte-enabled write, registered read, no reset.
REQ-035 The top level SHALL hold the FSM, clear counter, output pipeline and bypass.

Verification
REQ-036 Reset then idle: init_done rises exactly DEPTH cycles after reset deasserts (256 for defaults); reading any address afterwards returns 0x00.
REQ-037 Write addr 0x10 data 0xA5 be=1, then read 0x10: data_out=0xA5 with read_valid one cycle later for RD_LATENCY=1, two cycles later for RD_LATENCY=2.
REQ-038 DATA_W=32: write 0x11223344 be=4'b1111, then 0xAABBCCDD be=4'b0101, then read: 0x11BB33DD.
REQ-039 Same-address read+write, mem=0x01 and write 0x02: result 0x01 without the macro, 0x02 with DPRAM_WR_BYPASS_EN.
REQ-040 Reset pulsed at clear count 100 with read_en held high: no read_valid, and init_done rises DEPTH cycles after the second reset.
REQ-041 Reads of addresses 0..7 on consecutive cycles after prior writes: eight consecutive read_valid pulses with data in order.
